// File: rtl/text_scanout.sv
// 80x25 text-mode pixel generator: VRAM fetch, font fetch, CGA palette, blink and cursor.
// Fixed four-register pipeline from (DE, X, Y) to (R, G, B, DE_OUT).
module text_scanout #(
  parameter int TEXT_COLS  = 80,
  parameter int BLINK_BIT  = 4,
  parameter int CURSOR_TOP = 14
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        DE,
  input  logic [9:0]  X,
  input  logic [8:0]  Y,
  input  logic        FRAME,
  input  logic [6:0]  CURSOR_X,
  input  logic [4:0]  CURSOR_Y,
  input  logic        CURSOR_EN,
  output logic [10:0] VRAM_ADDR,
  input  logic [15:0] VRAM_Q,
  output logic [11:0] FONT_ADDR,
  input  logic [7:0]  FONT_Q,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        DE_OUT
);

  function automatic logic [11:0] pal(input logic [3:0] idx);
    case (idx)
      4'h0: pal = 12'h000;
      4'h1: pal = 12'h00A;
      4'h2: pal = 12'h0A0;
      4'h3: pal = 12'h0AA;
      4'h4: pal = 12'hA00;
      4'h5: pal = 12'hA0A;
      4'h6: pal = 12'hA50;
      4'h7: pal = 12'hAAA;
      4'h8: pal = 12'h555;
      4'h9: pal = 12'h55F;
      4'hA: pal = 12'h5F5;
      4'hB: pal = 12'h5FF;
      4'hC: pal = 12'hF55;
      4'hD: pal = 12'hF5F;
      4'hE: pal = 12'hFF5;
      default: pal = 12'hFFF;
    endcase
  endfunction

  logic [10:0] vram_addr_q, vram_addr_d;
  logic [2:0]  xlo1_q, xlo1_d, xlo2_q, xlo2_d;
  logic [3:0]  ylo1_q, ylo1_d;
  logic        de1_q, de1_d, de2_q, de2_d, de3_q, de3_d;
  logic        hit1_q, hit1_d, cur2_q, cur2_d, cur3_q, cur3_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic [7:0]  attr2_q, attr2_d, attr3_q, attr3_d;
  logic        bit3_q, bit3_d;
  logic [11:0] rgb_q, rgb_d;
  logic        de_out_q, de_out_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        phase_s, on_s;
  logic [3:0]  idx_s;

  // Next-state for every pipeline stage and the frame counter.
  always_comb begin
    phase_s     = cnt_q[BLINK_BIT];
    cnt_d       = FRAME ? cnt_q + 5'd1 : cnt_q;
    // Stage 1: cell address plus the per-pixel side data that travels with it.
    vram_addr_d = 11'(Y[8:4]) * 11'(TEXT_COLS) + 11'(X[9:3]);
    xlo1_d      = X[2:0];
    ylo1_d      = Y[3:0];
    de1_d       = DE;
    hit1_d      = CURSOR_EN && (X[9:3] == CURSOR_X) && (Y[8:4] == CURSOR_Y);
    // Stage 2: VRAM word is valid during this cycle.
    font_addr_d = {VRAM_Q[7:0], ylo1_q};
    attr2_d     = VRAM_Q[15:8];
    xlo2_d      = xlo1_q;
    de2_d       = de1_q;
    cur2_d      = hit1_q && (ylo1_q >= 4'(CURSOR_TOP));
    // Stage 3: font row is valid; bit 7 is the leftmost pixel, so index by ~x.
    bit3_d      = FONT_Q[~xlo2_q];
    attr3_d     = attr2_q;
    cur3_d      = cur2_q;
    de3_d       = de2_q;
    // Stage 4: blink/cursor overrides, palette and blanking.
    on_s        = bit3_q;
    if (attr3_q[7] && phase_s) begin
      on_s = 1'b0;
    end else if (cur3_q && !phase_s) begin
      on_s = 1'b1;
    end else begin
      on_s = bit3_q;
    end
    idx_s       = on_s ? attr3_q[3:0] : {1'b0, attr3_q[6:4]};
    rgb_d       = de3_q ? pal(idx_s) : 12'h000;
    de_out_d    = de3_q;
  end

  // Pipeline and frame-counter registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      vram_addr_q <= 11'd0;
      xlo1_q      <= 3'd0;
      ylo1_q      <= 4'd0;
      de1_q       <= 1'b0;
      hit1_q      <= 1'b0;
      font_addr_q <= 12'd0;
      attr2_q     <= 8'd0;
      xlo2_q      <= 3'd0;
      de2_q       <= 1'b0;
      cur2_q      <= 1'b0;
      bit3_q      <= 1'b0;
      attr3_q     <= 8'd0;
      cur3_q      <= 1'b0;
      de3_q       <= 1'b0;
      rgb_q       <= 12'd0;
      de_out_q    <= 1'b0;
      cnt_q       <= 5'd0;
    end else begin
      vram_addr_q <= vram_addr_d;
      xlo1_q      <= xlo1_d;
      ylo1_q      <= ylo1_d;
      de1_q       <= de1_d;
      hit1_q      <= hit1_d;
      font_addr_q <= font_addr_d;
      attr2_q     <= attr2_d;
      xlo2_q      <= xlo2_d;
      de2_q       <= de2_d;
      cur2_q      <= cur2_d;
      bit3_q      <= bit3_d;
      attr3_q     <= attr3_d;
      cur3_q      <= cur3_d;
      de3_q       <= de3_d;
      rgb_q       <= rgb_d;
      de_out_q    <= de_out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign VRAM_ADDR = vram_addr_q;
  assign FONT_ADDR = font_addr_q;
  assign R         = rgb_q[11:8];
  assign G         = rgb_q[7:4];
  assign B         = rgb_q[3:0];
  assign DE_OUT    = de_out_q;

endmodule

// File: tb/tb_text_scanout.sv
// Bench for text_scanout: behavioural VRAM/font memories, fixed vector table,
// reference-model scoreboard, and hand sequences for reset, blink and full lines.
module tb_text_scanout;

  logic        CLOCK = 1'b0;
  logic        RESET_N, DE, FRAME, CURSOR_EN, DE_OUT;
  logic [9:0]  X;
  logic [8:0]  Y;
  logic [6:0]  CURSOR_X;
  logic [4:0]  CURSOR_Y;
  logic [10:0] VRAM_ADDR;
  logic [15:0] VRAM_Q;
  logic [11:0] FONT_ADDR;
  logic [7:0]  FONT_Q;
  logic [3:0]  R, G, B;

  logic [15:0] vram_mem [0:2047];
  logic [7:0]  font_mem [0:4095];
  logic [11:0] pal_tab  [0:15] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                                   12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  logic [12:0] sb[$];
  int checks = 0;
  int errors = 0;
  int fcnt   = 0;
  int de_seen = 0;

  typedef struct {
    logic        de;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [12:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 CLOCK = ~CLOCK;

  assign VRAM_Q = vram_mem[VRAM_ADDR];
  assign FONT_Q = font_mem[FONT_ADDR];

  text_scanout dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .DE(DE), .X(X), .Y(Y), .FRAME(FRAME),
    .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y), .CURSOR_EN(CURSOR_EN),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_Q(VRAM_Q), .FONT_ADDR(FONT_ADDR), .FONT_Q(FONT_Q),
    .R(R), .G(G), .B(B), .DE_OUT(DE_OUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pixel: {DE_OUT, RGB} for a pixel given the current memories and frame count.
  function automatic logic [12:0] model(input logic de, input logic [9:0] x, input logic [8:0] y);
    int          addr;
    logic [15:0] w;
    logic [7:0]  g;
    logic        on, phase, cur;
    logic [3:0]  idx;
    addr  = int'(y[8:4]) * 80 + int'(x[9:3]);
    w     = vram_mem[addr];
    g     = font_mem[{w[7:0], y[3:0]}];
    on    = g[7 - int'(x[2:0])];
    phase = ((fcnt >> 4) & 1) == 1;
    cur   = CURSOR_EN && (x[9:3] == CURSOR_X) && (y[8:4] == CURSOR_Y) && (y[3:0] >= 4'd14);
    if (w[15] && phase) on = 1'b0;
    if (cur && !phase) on = 1'b1;
    idx   = on ? w[11:8] : {1'b0, w[14:12]};
    return de ? {1'b1, pal_tab[idx]} : 13'h0000;
  endfunction

  // One cycle: compare the output due now, then drive new inputs and queue their expectation.
  task automatic step(input logic de, input logic [9:0] x, input logic [8:0] y,
                      input logic fr, input logic [12:0] exp);
    logic [12:0] e;
    @(negedge CLOCK);
    if (sb.size() == 4) begin
      e = sb.pop_front();
      if (DE_OUT === 1'b1) de_seen++;
      chk("pixel", {19'd0, DE_OUT, R, G, B}, {19'd0, e});
    end
    DE = de; X = x; Y = y; FRAME = fr;
    if (fr) fcnt = (fcnt + 1) % 32;
    sb.push_back(exp);
  endtask

  task automatic pm(input logic de, input logic [9:0] x, input logic [8:0] y);
    step(de, x, y, 1'b0, model(de, x, y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 9'd0, 1'b0, 13'h0000);
  endtask

  task automatic frames(input int n);
    idle(4);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 9'd0, 1'b1, 13'h0000);
  endtask

  task automatic rand_px(input int n);
    for (int i = 0; i < n; i++)
      pm($urandom_range(0, 3) != 0, 10'($urandom_range(0, 639)), 9'($urandom_range(0, 399)));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) vram_mem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    vram_mem[162] = 16'h1F41;
    vram_mem[163] = 16'h1700;
    vram_mem[164] = 16'h9F41;
    vram_mem[165] = 16'h4F42;
    vram_mem[166] = 16'h6C43;
    for (int i = 0; i < 16; i++) font_mem[i] = 8'h00;
    font_mem[12'h413] = 8'h80;
    font_mem[12'h423] = 8'hFF;
    font_mem[12'h433] = 8'hF0;

    vecs.push_back('{1'b1, 10'd16, 9'd35, 13'h1FFF});
    vecs.push_back('{1'b1, 10'd17, 9'd35, 13'h100A});
    vecs.push_back('{1'b1, 10'd23, 9'd35, 13'h100A});
    vecs.push_back('{1'b0, 10'd16, 9'd35, 13'h0000});
    vecs.push_back('{1'b1, 10'd24, 9'd46, 13'h1AAA});
    vecs.push_back('{1'b1, 10'd31, 9'd47, 13'h1AAA});
    vecs.push_back('{1'b1, 10'd24, 9'd45, 13'h100A});
    vecs.push_back('{1'b1, 10'd28, 9'd32, 13'h100A});
    vecs.push_back('{1'b1, 10'd32, 9'd35, 13'h1FFF});
    vecs.push_back('{1'b1, 10'd33, 9'd35, 13'h100A});
    vecs.push_back('{1'b0, 10'd40, 9'd35, 13'h0000});
    vecs.push_back('{1'b1, 10'd41, 9'd35, 13'h1FFF});
    vecs.push_back('{1'b1, 10'd48, 9'd35, 13'h1F55});
    vecs.push_back('{1'b1, 10'd52, 9'd35, 13'h1A50});

    RESET_N = 1'b0; DE = 1'b0; X = 10'd0; Y = 9'd0; FRAME = 1'b0;
    CURSOR_EN = 1'b1; CURSOR_X = 7'd3; CURSOR_Y = 5'd2;
    repeat (3) @(negedge CLOCK);
    chk("reset_rgb_de", {19'd0, DE_OUT, R, G, B}, 32'd0);
    chk("reset_vram_addr", {21'd0, VRAM_ADDR}, 32'd0);
    chk("reset_font_addr", {20'd0, FONT_ADDR}, 32'd0);
    RESET_N = 1'b1;

    // Address path: cell (2,2) and its font row.
    step(1'b1, 10'd17, 9'd35, 1'b0, 13'h100A);
    @(posedge CLOCK); #1;
    chk("vram_addr", {21'd0, VRAM_ADDR}, 32'd162);
    idle(1);
    @(posedge CLOCK); #1;
    chk("font_addr", {20'd0, FONT_ADDR}, 32'h413);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i].de, vecs[i].x, vecs[i].y, 1'b0, vecs[i].exp);
    idle(4);
    rand_px(100);

    // Blink phase on after 16 frames: blinking glyph shows bg, cursor suppressed.
    frames(16);
    step(1'b1, 10'd32, 9'd35, 1'b0, 13'h100A);
    step(1'b1, 10'd24, 9'd46, 1'b0, 13'h100A);
    step(1'b1, 10'd16, 9'd35, 1'b0, 13'h1FFF);
    rand_px(100);

    // Reset mid-stream, with blink phase set, must blank outputs at once and clear the counter.
    for (int i = 0; i < 8; i++) pm(1'b1, 10'(16 + i), 9'd35);
    RESET_N = 1'b0;
    #1;
    chk("midreset_rgb_de", {19'd0, DE_OUT, R, G, B}, 32'd0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("midreset_hold", {19'd0, DE_OUT, R, G, B}, 32'd0);
    RESET_N = 1'b1;
    sb.delete();
    fcnt = 0;
    step(1'b1, 10'd32, 9'd35, 1'b0, 13'h1FFF);
    step(1'b1, 10'd24, 9'd46, 1'b0, 13'h1AAA);
    frames(16);
    step(1'b1, 10'd32, 9'd35, 1'b0, 13'h100A);
    frames(16);
    step(1'b1, 10'd32, 9'd35, 1'b0, 13'h1FFF);
    step(1'b1, 10'd24, 9'd46, 1'b0, 13'h1AAA);

    // Full visible line with no gaps.
    idle(4);
    de_seen = 0;
    for (int x = 0; x < 640; x++) pm(1'b1, 10'(x), 9'd100);
    idle(4);
    chk("line_de_count", de_seen, 32'd640);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
